// File: rtl/source_packer.sv
// Narrow-to-wide packer: gathers sixteen 32-bit words into one 512-bit line,
// queues finished lines in a small FIFO and hands them to the wide side over
// a valid/ready handshake. A flush pulse emits the current partial line with
// the unused upper lanes left at zero.
module source_packer #(
    parameter int OUT_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  din,
    input  logic         we,
    output logic         full,
    input  logic         flush,
    output logic [511:0] q,
    output logic         q_valid,
    input  logic         q_ready,
    output logic [4:0]   q_words,
    output logic [31:0]  wr_count,
    output logic [31:0]  rd_count
);

    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OUT_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Packing state: lanes collected so far, their count, and a flush that
    // is waiting for room in the output buffer.
    logic [511:0]     pack_q, pack_d;
    logic [3:0]       pcnt_q, pcnt_d;
    logic             flush_pend_q, flush_pend_d;

    // Output line buffer: circular storage of lines plus their word counts.
    logic [511:0]     mem_line_q  [OUT_DEPTH];
    logic [511:0]     mem_line_d  [OUT_DEPTH];
    logic [4:0]       mem_words_q [OUT_DEPTH];
    logic [4:0]       mem_words_d [OUT_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] ocnt_q, ocnt_d;

    logic [31:0]      wr_count_q, wr_count_d;
    logic [31:0]      rd_count_q, rd_count_d;

    // Intermediate combinational values.
    logic             obuf_full;
    logic             accept;
    logic             pop;
    logic             push;
    logic             flush_req;
    logic [511:0]     pack_next;
    logic [4:0]       pcnt_next;
    logic [4:0]       push_words;

    // Buffer fullness is judged before any same-cycle pop, so a handshake on
    // q never makes room for a push on the same edge.
    always_comb begin
        obuf_full = (ocnt_q == DEPTH_C);
        full      = flush_pend_q | ((pcnt_q == 4'd15) & obuf_full);
        accept    = we & ~full;
        q_valid   = (ocnt_q != '0);
        pop       = q_valid & q_ready;
        q         = q_valid ? mem_line_q[rd_ptr_q]  : '0;
        q_words   = q_valid ? mem_words_q[rd_ptr_q] : '0;
        wr_count  = wr_count_q;
        rd_count  = rd_count_q;
    end

    // Next-state logic: the accepted word is merged first, then a completed
    // line or a flush decides whether a line is pushed this cycle.
    always_comb begin
        pack_d       = pack_q;
        pcnt_d       = pcnt_q;
        flush_pend_d = flush_pend_q;
        mem_line_d   = mem_line_q;
        mem_words_d  = mem_words_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        ocnt_d       = ocnt_q;
        wr_count_d   = wr_count_q;
        rd_count_d   = rd_count_q;
        push         = 1'b0;
        push_words   = 5'd0;
        pack_next    = pack_q;
        pcnt_next    = {1'b0, pcnt_q};
        flush_req    = flush | flush_pend_q;

        if (accept) begin
            pack_next[{pcnt_q, 5'd0} +: 32] = din;
            pcnt_next  = {1'b0, pcnt_q} + 5'd1;
            wr_count_d = wr_count_q + 32'd1;
        end

        if (pcnt_next == 5'd16) begin
            push         = 1'b1;
            push_words   = 5'd16;
            flush_pend_d = 1'b0;
        end else if (flush_req) begin
            if (pcnt_next == 5'd0) begin
                flush_pend_d = 1'b0;
            end else if (!obuf_full) begin
                push         = 1'b1;
                push_words   = pcnt_next;
                flush_pend_d = 1'b0;
            end else begin
                flush_pend_d = 1'b1;
            end
        end

        if (push) begin
            mem_line_d[wr_ptr_q]  = pack_next;
            mem_words_d[wr_ptr_q] = push_words;
            wr_ptr_d              = wr_ptr_q + PTR_ONE;
            pack_d                = '0;
            pcnt_d                = 4'd0;
        end else begin
            pack_d = pack_next;
            pcnt_d = pcnt_next[3:0];
        end

        if (pop) begin
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            rd_count_d = rd_count_q + 32'd1;
        end

        if (push && !pop) begin
            ocnt_d = ocnt_q + CNT_ONE;
        end else if (!push && pop) begin
            ocnt_d = ocnt_q - CNT_ONE;
        end
    end

    // State register with synchronous active-low reset that discards all data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pack_q       <= '0;
            pcnt_q       <= 4'd0;
            flush_pend_q <= 1'b0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem_line_q[i]  <= '0;
                mem_words_q[i] <= 5'd0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ocnt_q       <= '0;
            wr_count_q   <= 32'd0;
            rd_count_q   <= 32'd0;
        end else begin
            pack_q       <= pack_d;
            pcnt_q       <= pcnt_d;
            flush_pend_q <= flush_pend_d;
            mem_line_q   <= mem_line_d;
            mem_words_q  <= mem_words_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ocnt_q       <= ocnt_d;
            wr_count_q   <= wr_count_d;
            rd_count_q   <= rd_count_d;
        end
    end

endmodule

// File: tb/tb_source_packer.sv
// Self-checking bench for source_packer: lines expected from the driven words
// are queued when stimulus is applied and compared when the DUT hands them off.
module tb_source_packer;

    logic         clk;
    logic         rst_n;
    logic [31:0]  din;
    logic         we;
    logic         full;
    logic         flush;
    logic [511:0] q;
    logic         q_valid;
    logic         q_ready;
    logic [4:0]   q_words;
    logic [31:0]  wr_count;
    logic [31:0]  rd_count;

    typedef struct {
        logic [511:0] line;
        logic [4:0]   words;
    } exp_t;

    exp_t         exp_q[$];
    logic [511:0] cur_line;
    int           cur_cnt;
    int           cmp_count;
    int           err_count;

    source_packer #(.OUT_DEPTH(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .we       (we),
        .full     (full),
        .flush    (flush),
        .q        (q),
        .q_valid  (q_valid),
        .q_ready  (q_ready),
        .q_words  (q_words),
        .wr_count (wr_count),
        .rd_count (rd_count)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
        cmp_count++;
        if (got !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Queue an expected line for the scoreboard.
    task automatic pushExp(input logic [511:0] line, input int words);
        exp_t e;
        e.line  = line;
        e.words = 5'(words);
        exp_q.push_back(e);
    endtask

    // Drive one cycle of write/flush and update the expected line model.
    task automatic applyStimulus(input logic [31:0] d, input bit w, input bit f, input bit exp_accept);
        din   = d;
        we    = w;
        flush = f;
        if (w && exp_accept) begin
            cur_line[cur_cnt*32 +: 32] = d;
            cur_cnt++;
            if (cur_cnt == 16) begin
                pushExp(cur_line, 16);
                cur_line = '0;
                cur_cnt  = 0;
            end
        end
        if (f && cur_cnt > 0) begin
            pushExp(cur_line, cur_cnt);
            cur_line = '0;
            cur_cnt  = 0;
        end
        cycle();
        we    = 1'b0;
        flush = 1'b0;
    endtask

    // Hold reset for two edges and drop everything the model was tracking.
    task automatic applyReset();
        rst_n = 1'b0;
        we    = 1'b0;
        flush = 1'b0;
        cycle();
        cycle();
        exp_q.delete();
        cur_line = '0;
        cur_cnt  = 0;
        rst_n = 1'b1;
    endtask

    // Wait (bounded) until every expected line has been handed off.
    task automatic waitDrain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || q_valid) && n < 200) begin
            cycle();
            n++;
        end
        checkOutput(tag, 512'(exp_q.size()), 512'(0));
    endtask

    // Scoreboard monitor: compare each handshaken line against the queue head.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && q_valid && q_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("extra_line", 512'(q_words), 512'(0));
            end else begin
                e = exp_q.pop_front();
                checkOutput("line_data", q, e.line);
                checkOutput("line_words", 512'(q_words), 512'(e.words));
            end
        end
    end

    // Hard time limit so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios.
    initial begin
        cmp_count = 0;
        err_count = 0;
        cur_line  = '0;
        cur_cnt   = 0;
        din       = '0;
        we        = 1'b0;
        flush     = 1'b0;
        q_ready   = 1'b0;
        rst_n     = 1'b0;
        cycle();
        applyReset();

        checkOutput("reset_q", q, 512'(0));
        checkOutput("reset_q_valid", 512'(q_valid), 512'(0));
        checkOutput("reset_q_words", 512'(q_words), 512'(0));
        checkOutput("reset_full", 512'(full), 512'(0));
        checkOutput("reset_wr_count", 512'(wr_count), 512'(0));
        checkOutput("reset_rd_count", 512'(rd_count), 512'(0));

        // T1: one full line with downstream always ready.
        q_ready = 1'b1;
        for (int k = 0; k < 16; k++) applyStimulus(32'(k), 1'b1, 1'b0, 1'b1);
        checkOutput("t1_q_valid_latency", 512'(q_valid), 512'(1));
        cycle();
        checkOutput("t1_wr_count", 512'(wr_count), 512'(16));
        checkOutput("t1_rd_count", 512'(rd_count), 512'(1));
        checkOutput("t1_q_valid_after_pop", 512'(q_valid), 512'(0));

        // T2: back-pressure until the packer refuses words.
        applyReset();
        q_ready = 1'b0;
        for (int k = 0; k < 47; k++) applyStimulus(32'h2000_0000 + 32'(k), 1'b1, 1'b0, 1'b1);
        checkOutput("t2_full_set", 512'(full), 512'(1));
        applyStimulus(32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        checkOutput("t2_rejected_wr_count", 512'(wr_count), 512'(47));
        checkOutput("t2_q_stable_words", 512'(q_words), 512'(16));
        q_ready = 1'b1;
        cycle();
        checkOutput("t2_full_after_pop", 512'(full), 512'(0));
        applyStimulus(32'h2000_002F, 1'b1, 1'b0, 1'b1);
        waitDrain("t2_drain");
        checkOutput("t2_rd_count", 512'(rd_count), 512'(3));
        checkOutput("t2_wr_count", 512'(wr_count), 512'(48));

        // T3: partial flush, flush with nothing packed, then a fresh full line.
        applyReset();
        q_ready = 1'b1;
        for (int k = 0; k < 5; k++) applyStimulus(32'hA0A0_0000 + 32'(k), 1'b1, 1'b0, 1'b1);
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b1);
        waitDrain("t3_partial_drain");
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b1);
        cycle();
        cycle();
        checkOutput("t3_empty_flush_rd", 512'(rd_count), 512'(1));
        for (int k = 0; k < 16; k++) begin
            q_ready = (k % 3) != 0;
            applyStimulus(32'h3300_0000 ^ 32'(k * 7919), 1'b1, 1'b0, 1'b1);
        end
        q_ready = 1'b1;
        waitDrain("t3_full_drain");
        checkOutput("t3_rd_count", 512'(rd_count), 512'(2));

        // T4: the 16th word arrives together with a flush.
        applyReset();
        q_ready = 1'b1;
        for (int k = 0; k < 15; k++) applyStimulus(32'h4400_0000 + 32'(k), 1'b1, 1'b0, 1'b1);
        applyStimulus(32'h4400_000F, 1'b1, 1'b1, 1'b1);
        waitDrain("t4_drain");
        cycle();
        checkOutput("t4_rd_count", 512'(rd_count), 512'(1));

        // T5: flush while the buffer is full is held pending until space opens.
        applyReset();
        q_ready = 1'b0;
        for (int k = 0; k < 32; k++) applyStimulus(32'h5500_0000 + 32'(k), 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) applyStimulus(32'h5A00_0000 + 32'(k), 1'b1, 1'b0, 1'b1);
        checkOutput("t5_full_before_flush", 512'(full), 512'(0));
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b1);
        checkOutput("t5_full_pending", 512'(full), 512'(1));
        applyStimulus(32'hBAD0_BAD0, 1'b1, 1'b0, 1'b0);
        checkOutput("t5_rejected_wr_count", 512'(wr_count), 512'(35));
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b1);
        checkOutput("t5_full_still", 512'(full), 512'(1));
        q_ready = 1'b1;
        waitDrain("t5_drain");
        checkOutput("t5_rd_count", 512'(rd_count), 512'(3));
        checkOutput("t5_full_released", 512'(full), 512'(0));

        // T6: reset with a partial line packed and a line queued.
        applyReset();
        q_ready = 1'b0;
        for (int k = 0; k < 23; k++) applyStimulus(32'h6600_0000 + 32'(k), 1'b1, 1'b0, 1'b1);
        checkOutput("t6_q_valid_before", 512'(q_valid), 512'(1));
        applyReset();
        checkOutput("t6_q_valid", 512'(q_valid), 512'(0));
        checkOutput("t6_wr_count", 512'(wr_count), 512'(0));
        checkOutput("t6_rd_count", 512'(rd_count), 512'(0));
        checkOutput("t6_full", 512'(full), 512'(0));
        q_ready = 1'b1;
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b1);
        cycle();
        cycle();
        checkOutput("t6_flush_nothing", 512'(q_valid), 512'(0));
        checkOutput("t6_rd_after_flush", 512'(rd_count), 512'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
